// File: rtl/tim_pwm.sv
// -----------------------------------------------------------------------------
// tim_pwm -- timer / PWM peripheral for slot 5 of the system IO hub.
//
// A prescaled 32-bit up-counter running 0..TOP, four compare-driven PWM
// outputs and a level overflow interrupt, programmed through the hub's
// decoded simple register bus.
//
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   waddr_i  write byte address (word aligned)
//   data_i   write data
//   sel_i    byte write strobes, bit k enables byte k
//   we_i     single-cycle write pulse
//   raddr_i  read byte address (word aligned)
//   rd_i     single-cycle read pulse
//   data_o   registered read data, held between reads
//   pwm_o    PWM outputs, registered
//   irq_o    overflow interrupt (OVF & IRQEN), registered
//
// Register map (byte offsets):
//   0x00 CTRL  [0] EN, [1] IRQEN, [2] ONESHOT, [15:8] PSC
//   0x04 STAT  [0] OVF (W1C), [1] RUN (mirrors EN)
//   0x08 TOP   period, counter runs 0..TOP
//   0x0C CNT   counter, a write loads it
//   0x10..0x1C CMP0..CMP3
// -----------------------------------------------------------------------------
module tim_pwm #(
    parameter int NCH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     waddr_i,
    input  logic [31:0]    data_i,
    input  logic [3:0]     sel_i,
    input  logic           we_i,
    input  logic [7:0]     raddr_i,
    input  logic           rd_i,
    output logic [31:0]    data_o,
    output logic [NCH-1:0] pwm_o,
    output logic           irq_o
);

    // Word indices (byte offset >> 2) of the registers.
    localparam logic [5:0] ADDR_CTRL = 6'h00;
    localparam logic [5:0] ADDR_STAT = 6'h01;
    localparam logic [5:0] ADDR_TOP  = 6'h02;
    localparam logic [5:0] ADDR_CNT  = 6'h03;
    localparam logic [5:0] ADDR_CMP  = 6'h04;

    // Register state
    logic                  en_q, en_d;
    logic                  irqen_q, irqen_d;
    logic                  oneshot_q, oneshot_d;
    logic [7:0]            psc_q, psc_d;
    logic                  ovf_q, ovf_d;
    logic [31:0]           top_q, top_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [NCH-1:0][31:0]  cmp_q, cmp_d;
    logic [7:0]            psc_cnt_q, psc_cnt_d;
    logic [31:0]           data_q, data_d;
    logic [NCH-1:0]        pwm_q, pwm_d;
    logic                  irq_q, irq_d;

    // Decoded bus strobes and internal events
    logic                  wr_ok;
    logic                  wr_ctrl, wr_stat, wr_top, wr_cnt;
    logic [NCH-1:0]        wr_cmp;
    logic                  tick;
    logic                  ovf_set;
    logic                  oneshot_stop;
    logic [31:0]           rd_val;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] apply_strobes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Write decode; misaligned addresses are treated as unmapped.
    always_comb begin
        wr_ok   = we_i && (waddr_i[1:0] == 2'b00);
        wr_ctrl = wr_ok && (waddr_i[7:2] == ADDR_CTRL);
        wr_stat = wr_ok && (waddr_i[7:2] == ADDR_STAT);
        wr_top  = wr_ok && (waddr_i[7:2] == ADDR_TOP);
        wr_cnt  = wr_ok && (waddr_i[7:2] == ADDR_CNT);
        for (int n = 0; n < NCH; n++) begin
            wr_cmp[n] = wr_ok && (waddr_i[7:2] == (ADDR_CMP + 6'(n)));
        end
    end

    // The tick fires in the cycle the prescaler reaches PSC; PSC = 0 ticks
    // every cycle.
    assign tick = en_q && (psc_cnt_q == psc_q);

    // Prescaler: held at 0 while stopped and restarted by any CTRL write so
    // that a new PSC always starts from a clean phase.
    always_comb begin
        psc_cnt_d = psc_cnt_q + 8'd1;
        if (!en_q || wr_ctrl || tick) begin
            psc_cnt_d = 8'd0;
        end
    end

    // Counter. A value loaded above TOP simply counts on through the 32-bit
    // wrap without flagging overflow, since only CNT == TOP overflows.
    // A bus write to CNT overrides whatever the tick would have done.
    always_comb begin
        cnt_d        = cnt_q;
        ovf_set      = 1'b0;
        oneshot_stop = 1'b0;
        if (tick) begin
            if (cnt_q == top_q) begin
                cnt_d        = 32'd0;
                ovf_set      = 1'b1;
                oneshot_stop = oneshot_q;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
        if (wr_cnt) begin
            cnt_d = apply_strobes(cnt_q, data_i, sel_i);
        end
    end

    // Control/status/compare registers. A CTRL write to EN beats the one-shot
    // stop, and an overflow set beats a same-cycle W1C.
    always_comb begin
        en_d      = en_q && !oneshot_stop;
        irqen_d   = irqen_q;
        oneshot_d = oneshot_q;
        psc_d     = psc_q;
        top_d     = top_q;
        cmp_d     = cmp_q;
        if (wr_ctrl && sel_i[0]) begin
            en_d      = data_i[0];
            irqen_d   = data_i[1];
            oneshot_d = data_i[2];
        end
        if (wr_ctrl && sel_i[1]) begin
            psc_d = data_i[15:8];
        end
        ovf_d = ovf_q;
        if (wr_stat && sel_i[0] && data_i[0]) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
        if (wr_top) begin
            top_d = apply_strobes(top_q, data_i, sel_i);
        end
        for (int n = 0; n < NCH; n++) begin
            if (wr_cmp[n]) begin
                cmp_d[n] = apply_strobes(cmp_q[n], data_i, sel_i);
            end
        end
    end

    // Read mux samples the registers before any same-cycle update, so a read
    // colliding with a write returns the old value.
    always_comb begin
        rd_val = 32'd0;
        if (raddr_i[1:0] == 2'b00) begin
            case (raddr_i[7:2])
                ADDR_CTRL: rd_val = {16'd0, psc_q, 5'd0, oneshot_q, irqen_q, en_q};
                ADDR_STAT: rd_val = {30'd0, en_q, ovf_q};
                ADDR_TOP:  rd_val = top_q;
                ADDR_CNT:  rd_val = cnt_q;
                default: begin
                    for (int n = 0; n < NCH; n++) begin
                        if (raddr_i[7:2] == (ADDR_CMP + 6'(n))) begin
                            rd_val = cmp_q[n];
                        end
                    end
                end
            endcase
        end
        data_d = rd_i ? rd_val : data_q;
    end

    // Registered outputs: PWM follows the counter one cycle behind, and IRQ
    // follows OVF one cycle behind.
    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            pwm_d[n] = en_q && (cnt_q < cmp_q[n]);
        end
        irq_d = ovf_q && irqen_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            irqen_q   <= 1'b0;
            oneshot_q <= 1'b0;
            psc_q     <= 8'd0;
            ovf_q     <= 1'b0;
            top_q     <= 32'd0;
            cnt_q     <= 32'd0;
            cmp_q     <= '0;
            psc_cnt_q <= 8'd0;
            data_q    <= 32'd0;
            pwm_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            irqen_q   <= irqen_d;
            oneshot_q <= oneshot_d;
            psc_q     <= psc_d;
            ovf_q     <= ovf_d;
            top_q     <= top_d;
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            psc_cnt_q <= psc_cnt_d;
            data_q    <= data_d;
            pwm_q     <= pwm_d;
            irq_q     <= irq_d;
        end
    end

    assign data_o = data_q;
    assign pwm_o  = pwm_q;
    assign irq_o  = irq_q;

endmodule

// File: tb/tb_tim_pwm.sv
// -----------------------------------------------------------------------------
// tb_tim_pwm -- self-checking bench for tim_pwm.
//
// Register read-back table, directed multi-cycle sequences for the timing
// corner cases, and randomized counter/PWM runs checked against an
// arithmetic model of the counter (ticks -> count value and overflow count).
// -----------------------------------------------------------------------------
module tb_tim_pwm;

    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_STAT = 8'h04;
    localparam logic [7:0] A_TOP  = 8'h08;
    localparam logic [7:0] A_CNT  = 8'h0C;
    localparam logic [7:0] A_CMP0 = 8'h10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  waddr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic [7:0]  raddr_i;
    logic        rd_i;
    logic [31:0] data_o;
    logic [3:0]  pwm_o;
    logic        irq_o;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    always #5 clk = ~clk;

    tim_pwm #(.NCH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .waddr_i (waddr_i),
        .data_i  (data_i),
        .sel_i   (sel_i),
        .we_i    (we_i),
        .raddr_i (raddr_i),
        .rd_i    (rd_i),
        .data_o  (data_o),
        .pwm_o   (pwm_o),
        .irq_o   (irq_o)
    );

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Advance n clock edges, ending 1 time unit after the last edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one bus cycle (write and/or read) across a single clock edge.
    task automatic applyStimulus(input bit do_wr, input logic [7:0] wa,
                                 input logic [31:0] wd, input logic [3:0] ws,
                                 input bit do_rd, input logic [7:0] ra);
        we_i    = do_wr;
        waddr_i = wa;
        data_i  = wd;
        sel_i   = ws;
        rd_i    = do_rd;
        raddr_i = ra;
        @(posedge clk);
        #1;
        we_i = 1'b0;
        rd_i = 1'b0;
    endtask

    task automatic busWrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        applyStimulus(1'b1, a, d, s, 1'b0, 8'h00);
    endtask

    task automatic busRead(input logic [7:0] a, output logic [31:0] d);
        applyStimulus(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, a);
        d = data_o;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
    endtask

    // Counter value and number of overflows after a given number of ticks,
    // starting from value s with period top. A start above top first runs
    // up to the 32-bit wrap (no overflow) and then behaves as if started at 0.
    function automatic void modelCounter(input longint s, input longint top,
                                         input longint ticks,
                                         output longint cnt, output longint ovfs);
        longint span;
        longint base;
        longint rem;
        span = longint'(64'h1_0000_0000) - s;
        if (s > top && ticks < span) begin
            cnt  = s + ticks;
            ovfs = 0;
        end else begin
            if (s > top) begin
                base = 0;
                rem  = ticks - span;
            end else begin
                base = s;
                rem  = ticks;
            end
            cnt  = (base + rem) % (top + 1);
            ovfs = (base + rem) / (top + 1);
        end
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rd;

        rst_n   = 1'b0;
        we_i    = 1'b0;
        rd_i    = 1'b0;
        waddr_i = 8'h00;
        raddr_i = 8'h00;
        data_i  = 32'h0;
        sel_i   = 4'h0;

        vecs[0]  = '{1'b0, A_CTRL,     32'h0,        4'h0, 32'h0000_0000};
        vecs[1]  = '{1'b1, A_TOP,      32'h1234_5678, 4'h5, 32'h0};
        vecs[2]  = '{1'b0, A_TOP,      32'h0,        4'h0, 32'h0034_0078};
        vecs[3]  = '{1'b0, 8'h40,      32'h0,        4'h0, 32'h0000_0000};
        vecs[4]  = '{1'b1, A_CTRL,     32'hFFFF_FF06, 4'hF, 32'h0};
        vecs[5]  = '{1'b0, A_CTRL,     32'h0,        4'h0, 32'h0000_FF06};
        vecs[6]  = '{1'b1, A_CTRL,     32'h0,        4'h2, 32'h0};
        vecs[7]  = '{1'b0, A_CTRL,     32'h0,        4'h0, 32'h0000_0006};
        vecs[8]  = '{1'b1, 8'h18,      32'hA5A5_A5A5, 4'hF, 32'h0};
        vecs[9]  = '{1'b0, 8'h18,      32'h0,        4'h0, 32'hA5A5_A5A5};
        vecs[10] = '{1'b1, A_CNT,      32'hDEAD_BEEF, 4'hC, 32'h0};
        vecs[11] = '{1'b0, A_CNT,      32'h0,        4'h0, 32'hDEAD_0000};
        vecs[12] = '{1'b1, 8'h20,      32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[13] = '{1'b0, 8'h20,      32'h0,        4'h0, 32'h0000_0000};
        vecs[14] = '{1'b0, A_STAT,     32'h0,        4'h0, 32'h0000_0000};
        vecs[15] = '{1'b1, 8'h1C,      32'h1122_3344, 4'h8, 32'h0};
        vecs[16] = '{1'b0, 8'h1C,      32'h0,        4'h0, 32'h1100_0000};
        vecs[17] = '{1'b0, A_CMP0,     32'h0,        4'h0, 32'h0000_0000};

        @(posedge clk);
        #1;
        idle(1);
        rst_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("reset data_o", data_o, 32'h0);
        checkOutput("reset pwm_o", {28'h0, pwm_o}, 32'h0);
        checkOutput("reset irq_o", {31'h0, irq_o}, 32'h0);

        $display("[TB] register read-back table");
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_wr) begin
                busWrite(vecs[i].addr, vecs[i].data, vecs[i].sel);
            end else begin
                busRead(vecs[i].addr, rd);
                checkOutput($sformatf("table row %0d", i), rd, vecs[i].exp);
            end
        end

        $display("[TB] free-run without prescaler");
        doReset();
        busWrite(A_TOP, 32'd9, 4'hF);
        busWrite(A_CMP0, 32'd3, 4'hF);
        busWrite(A_CTRL, 32'h1, 4'hF);
        for (int k = 1; k <= 20; k++) begin
            idle(1);
            checkOutput($sformatf("freerun pwm0 k=%0d", k), {31'h0, pwm_o[0]},
                        {31'h0, ((k - 1) % 10) < 3});
            checkOutput($sformatf("freerun irq k=%0d", k), {31'h0, irq_o}, 32'h0);
        end
        busRead(A_STAT, rd);
        checkOutput("freerun stat", rd, 32'h3);
        busWrite(A_CTRL, 32'h3, 4'hF);
        checkOutput("freerun irq before irqen", {31'h0, irq_o}, 32'h0);
        idle(1);
        checkOutput("freerun irq after irqen", {31'h0, irq_o}, 32'h1);

        $display("[TB] prescaler and one-shot");
        doReset();
        busWrite(A_TOP, 32'd2, 4'hF);
        busWrite(A_CMP0, 32'd10, 4'hF);
        busWrite(A_CTRL, 32'h0000_0307, 4'hF);
        for (int k = 1; k <= 14; k++) begin
            idle(1);
            checkOutput($sformatf("oneshot irq k=%0d", k), {31'h0, irq_o}, {31'h0, k >= 13});
            checkOutput($sformatf("oneshot pwm0 k=%0d", k), {31'h0, pwm_o[0]}, {31'h0, k <= 12});
        end
        busRead(A_CTRL, rd);
        checkOutput("oneshot ctrl", rd, 32'h0000_0306);
        busRead(A_CNT, rd);
        checkOutput("oneshot cnt", rd, 32'h0);
        busRead(A_STAT, rd);
        checkOutput("oneshot stat", rd, 32'h1);
        checkOutput("oneshot pwm", {28'h0, pwm_o}, 32'h0);

        $display("[TB] edge compares");
        doReset();
        busWrite(A_TOP, 32'd4, 4'hF);
        busWrite(A_CMP0, 32'd2, 4'hF);
        busWrite(A_CMP0 + 8'h4, 32'd0, 4'hF);
        busWrite(A_CMP0 + 8'h8, 32'd5, 4'hF);
        busWrite(A_CMP0 + 8'hC, 32'hFFFF_FFFF, 4'hF);
        busWrite(A_CTRL, 32'h1, 4'hF);
        for (int k = 1; k <= 12; k++) begin
            idle(1);
            checkOutput($sformatf("edge pwm k=%0d", k), {28'h0, pwm_o},
                        {28'h0, 3'b110, ((k - 1) % 5) < 2});
        end

        $display("[TB] collisions");
        doReset();
        busWrite(A_TOP, 32'd3, 4'hF);
        busWrite(A_CTRL, 32'h1, 4'hF);
        idle(7);
        busWrite(A_STAT, 32'h1, 4'h1);
        busRead(A_STAT, rd);
        checkOutput("ovf set beats w1c", rd, 32'h3);
        busWrite(A_STAT, 32'h1, 4'h1);
        busRead(A_STAT, rd);
        checkOutput("w1c clears ovf", rd, 32'h2);
        busWrite(A_CNT, 32'd7, 4'hF);
        busRead(A_CNT, rd);
        checkOutput("cnt write beats tick", rd, 32'd7);
        applyStimulus(1'b1, A_TOP, 32'h20, 4'hF, 1'b1, A_TOP);
        checkOutput("read returns pre-write", data_o, 32'd3);
        busRead(A_TOP, rd);
        checkOutput("top after write", rd, 32'h20);

        $display("[TB] reset mid-run");
        doReset();
        busWrite(A_TOP, 32'd100, 4'hF);
        busWrite(A_CMP0, 32'd200, 4'hF);
        busWrite(A_CTRL, 32'h3, 4'hF);
        idle(48);
        busRead(A_TOP, rd);
        checkOutput("midrun top", rd, 32'd100);
        checkOutput("midrun pwm0", {31'h0, pwm_o[0]}, 32'h1);
        doReset();
        checkOutput("midrun reset data_o", data_o, 32'h0);
        checkOutput("midrun reset pwm_o", {28'h0, pwm_o}, 32'h0);
        checkOutput("midrun reset irq_o", {31'h0, irq_o}, 32'h0);
        busRead(A_CNT, rd);
        checkOutput("midrun reset cnt", rd, 32'h0);
        busRead(A_CTRL, rd);
        checkOutput("midrun reset ctrl", rd, 32'h0);

        $display("[TB] randomized runs");
        doReset();
        for (int trial = 0; trial < 10; trial++) begin
            int unsigned psc;
            int unsigned top;
            longint      s;
            longint      cmp_val[4];
            longint      c;
            longint      o;
            logic [3:0]  exp_pwm;

            psc = $urandom_range(0, 3);
            top = $urandom_range(0, 12);
            if ($urandom_range(0, 3) == 0) begin
                s = longint'(32'hFFFF_FFFF) - longint'($urandom_range(0, 6));
            end else begin
                s = longint'($urandom_range(0, top));
            end
            for (int n = 0; n < 4; n++) begin
                case ($urandom_range(0, 3))
                    0:       cmp_val[n] = 0;
                    1:       cmp_val[n] = longint'(32'hFFFF_FFFF);
                    default: cmp_val[n] = longint'($urandom_range(0, top + 2));
                endcase
            end

            busWrite(A_CTRL, 32'h0, 4'hF);
            busWrite(A_TOP, top, 4'hF);
            for (int n = 0; n < 4; n++) begin
                busWrite(A_CMP0 + 8'(4 * n), cmp_val[n][31:0], 4'hF);
            end
            busWrite(A_CNT, s[31:0], 4'hF);
            busWrite(A_STAT, 32'h1, 4'h1);
            busWrite(A_CTRL, {16'h0, 8'(psc), 8'h03}, 4'hF);

            for (int k = 1; k <= 40; k++) begin
                idle(1);
                modelCounter(s, longint'(top), longint'((k - 1) / (psc + 1)), c, o);
                for (int n = 0; n < 4; n++) begin
                    exp_pwm[n] = (c < cmp_val[n]);
                end
                checkOutput($sformatf("rand t%0d pwm k=%0d", trial, k), {28'h0, pwm_o},
                            {28'h0, exp_pwm});
                checkOutput($sformatf("rand t%0d irq k=%0d", trial, k), {31'h0, irq_o},
                            {31'h0, o > 0});
            end
            busRead(A_CNT, rd);
            modelCounter(s, longint'(top), longint'(40 / (psc + 1)), c, o);
            checkOutput($sformatf("rand t%0d cnt", trial), rd, c[31:0]);
            busRead(A_STAT, rd);
            modelCounter(s, longint'(top), longint'(41 / (psc + 1)), c, o);
            checkOutput($sformatf("rand t%0d stat", trial), rd, {30'h0, 1'b1, o > 0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
